// File: rtl/prbs_gen_tx.sv
// PRBS31 (x^31 + x^28 + 1) byte source for BER testing with start/stop control,
// valid/ready handshake and single-shot / periodic bit-0 error injection.
module prbs_gen_tx #(
  parameter logic [30:0] SEED     = 31'h597957A0,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                ready,
  input  logic                inj_single,
  input  logic [PERIOD_W-1:0] err_period,
  output logic [7:0]          prbs,
  output logic                prbs_valid,
  output logic                busy,
  output logic [31:0]         byte_cnt,
  output logic [PERIOD_W-1:0] inj_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [30:0]         lfsr, lfsr_next, src;
  logic                inj_pending, pending_next;
  logic [PERIOD_W-1:0] period, per_cnt, per_cnt_next;
  logic [PERIOD_W-1:0] cur_period, cur_per_cnt, base_inj_cnt, inj_cnt_next;
  logic [31:0]         base_byte_cnt, byte_cnt_next;
  logic [7:0]          fresh, prbs_next;
  logic                do_load, do_count, per_hit, inj;

  // Eight serial LFSR steps collapsed into one parallel step; bit 7 is oldest.
  function automatic logic [7:0] next_byte(input logic [30:0] d);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[7-k] = d[30-k] ^ d[27-k];
    end
    return b;
  endfunction

  always_comb begin
    state_next    = state;
    do_load       = 1'b0;
    do_count      = 1'b0;
    src           = lfsr;
    cur_period    = period;
    cur_per_cnt   = per_cnt;
    base_byte_cnt = byte_cnt;
    base_inj_cnt  = inj_cnt;
    case (state)
      IDLE: if (start && !stop) state_next = LOAD;
      LOAD: begin
        do_load       = 1'b1;
        src           = SEED;
        cur_period    = err_period;
        cur_per_cnt   = '0;
        base_byte_cnt = '0;
        base_inj_cnt  = '0;
        state_next    = RUN;
      end
      RUN: begin
        if (ready) begin
          do_count = 1'b1;
          do_load  = !stop;
        end
        if (stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    fresh   = next_byte(src);
    per_hit = (cur_period != '0) && (cur_per_cnt == cur_period - PERIOD_W'(1));
    inj     = inj_pending | per_hit;

    byte_cnt_next = do_count ? base_byte_cnt + 32'd1 : base_byte_cnt;
    lfsr_next     = lfsr;
    prbs_next     = prbs;
    per_cnt_next  = cur_per_cnt;
    inj_cnt_next  = base_inj_cnt;
    pending_next  = inj_pending | inj_single;

    // The LFSR always advances with the clean byte so injected errors stay isolated.
    if (do_load) begin
      lfsr_next    = {src[22:0], fresh};
      prbs_next    = fresh ^ {7'b0, inj};
      per_cnt_next = (per_hit || cur_period == '0) ? '0 : cur_per_cnt + PERIOD_W'(1);
      if (inj && base_inj_cnt != '1) inj_cnt_next = base_inj_cnt + PERIOD_W'(1);
      pending_next = inj_single;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= SEED;
      prbs        <= '0;
      prbs_valid  <= 1'b0;
      busy        <= 1'b0;
      byte_cnt    <= '0;
      inj_cnt     <= '0;
      inj_pending <= 1'b0;
      per_cnt     <= '0;
      period      <= '0;
    end else begin
      state       <= state_next;
      lfsr        <= lfsr_next;
      prbs        <= prbs_next;
      prbs_valid  <= (state_next == RUN);
      busy        <= (state_next != IDLE);
      byte_cnt    <= byte_cnt_next;
      inj_cnt     <= inj_cnt_next;
      inj_pending <= pending_next;
      per_cnt     <= per_cnt_next;
      if (state == LOAD) period <= err_period;
    end
  end

endmodule
